ctrl_pipe_hazard: RTL and testbench

Consumer end of the decoded-control interface. It takes the per-instruction control bundle produced in ID and stages it through the ID/EX, EX/MEM and MEM/WB pipeline registers. Alongside that it handles load-use stalls, branch/jump flushes and operand-forward selects. It sits between the opcode decoder and the EX/MEM/WB datapath of the 5-stage pipelined CPU.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_pipe_hazard_hazard_detect.sv | 96 +++++++++
 rtl/ctrl_pipe_hazard.sv | 108 ++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-bundle layout, ALU and forward codes.
// Used by ctrl_pipe_hazard and hazard_detect.
package ctrl_pkg;

  localparam int CW = 10;

  localparam int B_JUMP       = 0;
  localparam int B_BRANCH     = 1;
  localparam int B_MEM_WRITE  = 2;
  localparam int B_MEM_READ   = 3;
  localparam int B_REG_WRITE  = 4;
  localparam int B_MEM_TO_REG = 5;
  localparam int B_ALU_SRC    = 6;
  localparam int B_REG_DST    = 7;
  localparam int B_ALU_OP     = 8;

  localparam int M_MEM_WRITE  = 0;
  localparam int M_MEM_READ   = 1;
  localparam int M_REG_WRITE  = 2;
  localparam int M_MEM_TO_REG = 3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [CW-1:0] BUBBLE = '0;

  function automatic logic [3:0] mem_bits(
    input logic [CW-1:0] c
  );
    return {c[B_MEM_TO_REG], c[B_REG_WRITE],
            c[B_MEM_READ], c[B_MEM_WRITE]};
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_hazard_detect.sv
// Stall, flush and operand-forward select logic.
// CTRL_FWD_EN: forwarding on, load-use is the only stall.
module hazard_detect
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              id_jump,
  input  logic              id_branch,
  input  logic              id_reg_dst,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_branch_taken,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  output logic              stall,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic use_rs;
  logic use_rt;
  logic hit_ex;
  logic hit_mem;
  logic stall_raw;

  // Which ID sources collide with an in-flight producer
  always_comb begin
    use_rs  = !id_jump;
    use_rt  = id_reg_dst | id_mem_write | id_branch;
    hit_ex  = (ex_dst != '0) &&
              ((use_rs && id_rs == ex_dst) ||
               (use_rt && id_rt == ex_dst));
    hit_mem = (mem_dst != '0) &&
              ((use_rs && id_rs == mem_dst) ||
               (use_rt && id_rt == mem_dst));
  end

`ifdef CTRL_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_reg_write, hit_mem};

  // Only a load result is too late to forward
  always_comb begin
    stall_raw = ex_mem_read && hit_ex;
  end

  // EX operand selects, MEM result is newer than WB
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_reg_write && mem_dst == ex_rs)
      fwd_a = FWD_MEM;
    else if (wb_reg_write && wb_dst == ex_rs)
      fwd_a = FWD_WB;
    if (mem_reg_write && mem_dst == ex_rt)
      fwd_b = FWD_MEM;
    else if (wb_reg_write && wb_dst == ex_rt)
      fwd_b = FWD_WB;
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_mem_read, ex_rs, ex_rt,
                          wb_reg_write, wb_dst};

  // Wait until every producer has left MEM
  always_comb begin
    stall_raw = (ex_reg_write && hit_ex) ||
                (mem_reg_write && hit_mem);
  end

  // Operands always come from the register file
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

  // A taken branch squashes ID, so it never stalls
  always_comb begin
    stall      = id_valid && stall_raw && !ex_branch_taken;
    flush_ifid = ex_branch_taken ||
                 (id_valid && id_jump && !stall_raw);
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM, MEM/WB control registers with hazard unit.
// CTRL_FWD_EN selects forwarding vs. stall-until-WB.
module ctrl_pipe_hazard
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_dst,
  output logic [3:0]        mem_ctrl,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] id_dst;
  logic [CTRL_W-1:0] id_stage;
  logic              bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_hzd (
    .id_valid        (id_valid),
    .id_jump         (id_ctrl[B_JUMP]),
    .id_branch       (id_ctrl[B_BRANCH]),
    .id_reg_dst      (id_ctrl[B_REG_DST]),
    .id_mem_write    (id_ctrl[B_MEM_WRITE]),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_read     (ex_ctrl[B_MEM_READ]),
    .ex_reg_write    (ex_ctrl[B_REG_WRITE]),
    .ex_dst          (ex_dst),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .mem_reg_write   (mem_ctrl[M_REG_WRITE]),
    .mem_dst         (mem_dst),
    .wb_reg_write    (wb_reg_write),
    .wb_dst          (wb_dst),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  // Pick destination, drop writes to $0, decide bubble
  always_comb begin
    id_dst = id_ctrl[B_MEM_READ] ? id_rt :
             (id_ctrl[B_REG_DST] ? id_rd : id_rt);
    id_stage = id_ctrl;
    id_stage[B_REG_WRITE] = id_ctrl[B_REG_WRITE] &&
                            (id_dst != '0);
    bubble = !id_valid || stall ||
             ex_branch_taken || id_ctrl[B_JUMP];
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl <= BUBBLE;
      ex_dst  <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
    end else if (bubble) begin
      ex_ctrl <= BUBBLE;
      ex_dst  <= '0;
      ex_rs   <= '0;
      ex_rt   <= '0;
    end else begin
      ex_ctrl <= id_stage;
      ex_dst  <= id_dst;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
    end
  end

  // EX/MEM and MEM/WB registers, never held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl      <= '0;
      mem_dst       <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dst        <= '0;
    end else begin
      mem_ctrl      <= mem_bits(ex_ctrl);
      mem_dst       <= ex_dst;
      wb_reg_write  <= mem_ctrl[M_REG_WRITE];
      wb_mem_to_reg <= mem_ctrl[M_MEM_TO_REG];
      wb_dst        <= mem_dst;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Vector table plus stage scoreboard for ctrl_pipe_hazard.
// Tables follow CTRL_FWD_EN as the RTL does.
module tb_ctrl_pipe_hazard;

  localparam logic [9:0] LW  = 10'h078;
  localparam logic [9:0] RT  = 10'h290;
  localparam logic [9:0] RT0 = 10'h280;
  localparam logic [9:0] BEQ = 10'h102;
  localparam logic [9:0] JMP = 10'h001;
  localparam logic [9:0] NOP = 10'h000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_ctrl = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       ex_branch_taken = 1'b0;
  logic       stall;
  logic       flush_ifid;
  logic [9:0] ex_ctrl;
  logic [4:0] ex_dst;
  logic [3:0] mem_ctrl;
  logic [4:0] mem_dst;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  logic [4:0] wb_dst;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  typedef struct {
    logic       v;
    logic [9:0] c;
    logic [4:0] rs, rt, rd;
    logic       tk;
    logic       st, fl;
    logic [1:0] fa, fb;
    logic [9:0] xc;
    logic [4:0] xd;
  } vec_t;

  typedef struct {
    logic [9:0] c;
    logic [4:0] d;
  } stg_t;

  vec_t tv[$];
  stg_t sb[$];
  int   checks = 0;
  int   fails = 0;

  ctrl_pipe_hazard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_ctrl         (id_ctrl),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .ex_ctrl         (ex_ctrl),
    .ex_dst          (ex_dst),
    .mem_ctrl        (mem_ctrl),
    .mem_dst         (mem_dst),
    .wb_reg_write    (wb_reg_write),
    .wb_mem_to_reg   (wb_mem_to_reg),
    .wb_dst          (wb_dst),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic [9:0] c,
    input int rs, input int rt, input int rd,
    input logic tk, input logic st, input logic fl,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [9:0] xc, input int xd);
    vec_t t;
    t.v = v;  t.c = c;
    t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.tk = tk; t.st = st; t.fl = fl;
    t.fa = fa; t.fb = fb;
    t.xc = xc; t.xd = 5'(xd);
    return t;
  endfunction

  task automatic step(input vec_t t, input int i);
    stg_t e;
    @(negedge clk);
    id_valid = t.v;   id_ctrl = t.c;
    id_rs = t.rs;     id_rt = t.rt;
    id_rd = t.rd;     ex_branch_taken = t.tk;
    #1;
    chk($sformatf("stall[%0d]", i), 32'(stall), 32'(t.st));
    chk($sformatf("flush[%0d]", i), 32'(flush_ifid), 32'(t.fl));
    chk($sformatf("fwd_a[%0d]", i), 32'(fwd_a), 32'(t.fa));
    chk($sformatf("fwd_b[%0d]", i), 32'(fwd_b), 32'(t.fb));
    e.c = t.xc;
    e.d = t.xd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk($sformatf("ex_ctrl[%0d]", i), 32'(ex_ctrl), 32'(t.xc));
    chk($sformatf("ex_dst[%0d]", i), 32'(ex_dst), 32'(t.xd));
    chk($sformatf("mem_ctrl[%0d]", i), 32'(mem_ctrl),
        32'({sb[1].c[5], sb[1].c[4], sb[1].c[3], sb[1].c[2]}));
    chk($sformatf("mem_dst[%0d]", i), 32'(mem_dst), 32'(sb[1].d));
    chk($sformatf("wb_rw[%0d]", i), 32'(wb_reg_write),
        32'(sb[0].c[4]));
    chk($sformatf("wb_m2r[%0d]", i), 32'(wb_mem_to_reg),
        32'(sb[0].c[5]));
    chk($sformatf("wb_dst[%0d]", i), 32'(wb_dst), 32'(sb[0].d));
    void'(sb.pop_front());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_flush"}, 32'(flush_ifid), 32'd0);
    chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
    chk({tag, "_ex_dst"}, 32'(ex_dst), 32'd0);
    chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
    chk({tag, "_mem_dst"}, 32'(mem_dst), 32'd0);
    chk({tag, "_wb_rw"}, 32'(wb_reg_write), 32'd0);
    chk({tag, "_wb_m2r"}, 32'(wb_mem_to_reg), 32'd0);
    chk({tag, "_wb_dst"}, 32'(wb_dst), 32'd0);
    chk({tag, "_fwd_a"}, 32'(fwd_a), 32'd0);
    chk({tag, "_fwd_b"}, 32'(fwd_b), 32'd0);
  endtask

  initial begin
`ifdef CTRL_FWD_EN
    tv.push_back(mk(1, LW,  2,  8,  0, 0, 0, 0, 2'b00, 2'b00, LW,  8));
    tv.push_back(mk(1, RT,  8, 10,  9, 0, 1, 0, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  8, 10,  9, 0, 0, 0, 2'b00, 2'b00, RT,  9));
    tv.push_back(mk(0, NOP, 0,  0,  0, 0, 0, 0, 2'b01, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  1,  2,  8, 0, 0, 0, 2'b00, 2'b00, RT,  8));
    tv.push_back(mk(1, RT, 10,  8, 11, 0, 0, 0, 2'b00, 2'b00, RT, 11));
    tv.push_back(mk(0, NOP, 0,  0,  0, 0, 0, 0, 2'b00, 2'b10, NOP, 0));
    tv.push_back(mk(1, LW,  2, 12,  0, 0, 0, 0, 2'b00, 2'b00, LW, 12));
    tv.push_back(mk(1, BEQ,12,  5,  0, 1, 0, 1, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, JMP, 0,  0,  0, 0, 0, 1, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  1,  2,  0, 0, 0, 0, 2'b00, 2'b00, RT0, 0));
    tv.push_back(mk(1, RT,  0,  0, 13, 0, 0, 0, 2'b00, 2'b00, RT, 13));
`else
    tv.push_back(mk(1, LW,  2,  8,  0, 0, 0, 0, 2'b00, 2'b00, LW,  8));
    tv.push_back(mk(1, RT,  8, 10,  9, 0, 1, 0, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  8, 10,  9, 0, 1, 0, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  8, 10,  9, 0, 0, 0, 2'b00, 2'b00, RT,  9));
    tv.push_back(mk(1, RT,  1,  2,  8, 0, 0, 0, 2'b00, 2'b00, RT,  8));
    tv.push_back(mk(1, RT, 10,  8, 11, 0, 1, 0, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT, 10,  8, 11, 0, 1, 0, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT, 10,  8, 11, 0, 0, 0, 2'b00, 2'b00, RT, 11));
    tv.push_back(mk(1, LW,  2, 12,  0, 0, 0, 0, 2'b00, 2'b00, LW, 12));
    tv.push_back(mk(1, BEQ,12,  5,  0, 1, 0, 1, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, JMP, 0,  0,  0, 0, 0, 1, 2'b00, 2'b00, NOP, 0));
    tv.push_back(mk(1, RT,  1,  2,  0, 0, 0, 0, 2'b00, 2'b00, RT0, 0));
    tv.push_back(mk(1, RT,  0,  0, 13, 0, 0, 0, 2'b00, 2'b00, RT, 13));
`endif
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0, NOP, 0, 0, 0, 0, 0, 0,
                      2'b00, 2'b00, NOP, 0));

    sb.push_back('{10'h0, 5'h0});
    sb.push_back('{10'h0, 5'h0});

    #2;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      step(tv[i], i);

    // Fill EX and MEM, then reset between edges
    @(negedge clk);
    id_valid = 1'b1; id_ctrl = RT;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    ex_branch_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_ex_ctrl", 32'(ex_ctrl), 32'(RT));
    chk("pre_mem_ctrl", 32'(mem_ctrl), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    @(posedge clk);
    #1;
    chk_zero("held");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
